// File: rtl/mod_acc_pkg.sv
// Shared types, constants and sizing helpers for the mod_acc streaming accumulator.
package mod_acc_pkg;

    typedef enum logic [1:0] {
        SIDE_RST_NONE,
        SIDE_RST_ZERO,
        SIDE_RST_ONE
    } side_rst_e;

    localparam int MOD_ACC_RST_SIDE_ZERO_BIT = 0;
    localparam int MOD_ACC_RST_SIDE_ONE_BIT  = 1;

    function automatic int get_acc_cnt_w(input int acc_nb);
        return (acc_nb > 1) ? $clog2(acc_nb) : 1;
    endfunction

    // A zero-width side bus is carried as one dummy bit so port widths stay legal.
    function automatic int get_side_w(input int side_w);
        return (side_w > 0) ? side_w : 1;
    endfunction

    // The zero request wins when both reset bits are set.
    function automatic side_rst_e get_side_rst(input logic [1:0] rst_side);
        if (rst_side[MOD_ACC_RST_SIDE_ZERO_BIT])
            return SIDE_RST_ZERO;
        else if (rst_side[MOD_ACC_RST_SIDE_ONE_BIT])
            return SIDE_RST_ONE;
        else
            return SIDE_RST_NONE;
    endfunction

endpackage

// File: rtl/mod_acc_if.sv
// Input/output stream bundle of mod_acc; out_err exists only with MOD_ACC_INPUT_CHECK_EN.
interface mod_acc_if
    import mod_acc_pkg::*;
#(
    parameter int MOD_W  = 64,
    parameter int SIDE_W = 0
);
    localparam int SIDE_WI = get_side_w(SIDE_W);

    logic [MOD_W-1:0]   a;
    logic               in_avail;
    logic [SIDE_WI-1:0] in_side;
    logic [MOD_W-1:0]   z;
    logic               out_avail;
    logic [SIDE_WI-1:0] out_side;
`ifdef MOD_ACC_INPUT_CHECK_EN
    logic               out_err;

    modport master (
        output a, in_avail, in_side,
        input  z, out_avail, out_side, out_err
    );

    modport slave (
        input  a, in_avail, in_side,
        output z, out_avail, out_side, out_err
    );
`else
    modport master (
        output a, in_avail, in_side,
        input  z, out_avail, out_side
    );

    modport slave (
        input  a, in_avail, in_side,
        output z, out_avail, out_side
    );
`endif

endinterface

// File: rtl/mod_acc_add_core.sv
// Combinational modular adder: (x + y) mod MOD_M for x, y < MOD_M with one conditional subtract.
module mod_acc_add_core
    import mod_acc_pkg::*;
#(
    parameter int               MOD_W = 64,
    parameter logic [MOD_W-1:0] MOD_M = {{(MOD_W-MOD_W/2){1'b1}}, {(MOD_W/2-1){1'b0}}, 1'b1}
) (
    input  logic [MOD_W-1:0] i_x,
    input  logic [MOD_W-1:0] i_y,
    output logic [MOD_W-1:0] o_sum
);

    logic [MOD_W:0]   w_sum;
    logic [MOD_W-1:0] w_diff;
    logic             w_ge;

    assign w_sum  = {1'b0, i_x} + {1'b0, i_y};
    // The carry bit is dropped on purpose: when w_ge holds the true difference fits in MOD_W bits.
    assign w_diff = w_sum[MOD_W-1:0] - MOD_M;
    assign w_ge   = (w_sum >= {1'b0, MOD_M});
    assign o_sum  = w_ge ? w_diff : w_sum[MOD_W-1:0];

endmodule

// File: rtl/mod_acc.sv
// mod_acc: sums each group of ACC_NB valid inputs modulo MOD_M and emits one pulse per group.
// Define MOD_ACC_INPUT_CHECK_EN to add the sticky out_err flag for inputs >= MOD_M.
module mod_acc
    import mod_acc_pkg::*;
#(
    parameter int               MOD_W    = 64,
    parameter logic [MOD_W-1:0] MOD_M    = {{(MOD_W-MOD_W/2){1'b1}}, {(MOD_W/2-1){1'b0}}, 1'b1},
    parameter int               ACC_NB   = 4,
    parameter int               IN_PIPE  = 1,
    parameter int               SIDE_W   = 0,
    parameter logic [1:0]       RST_SIDE = 2'b00
) (
    input  logic       clk,
    input  logic       s_rst_n,
    mod_acc_if.slave   bus
);

    localparam int               CNT_W         = get_acc_cnt_w(ACC_NB);
    localparam int               SIDE_WI       = get_side_w(SIDE_W);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(ACC_NB - 1);
    localparam side_rst_e        SIDE_RST_MODE = get_side_rst(RST_SIDE);
    localparam logic [SIDE_WI-1:0] SIDE_RST_VAL =
        (SIDE_RST_MODE == SIDE_RST_ONE) ? {SIDE_WI{1'b1}} : {SIDE_WI{1'b0}};

    logic [MOD_W-1:0] w_s0_a;
    logic             w_s0_avail;
    logic [MOD_W-1:0] w_acc_op;
    logic [MOD_W-1:0] w_result;
    logic             w_last;

    logic [MOD_W-1:0] r_acc;
    logic [MOD_W-1:0] r_z;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_avail;

    // ---------------- s0: optional input register ----------------
    generate
        if (IN_PIPE != 0) begin : g_in_pipe
            logic [MOD_W-1:0] r_a;
            logic             r_avail;

            always_ff @(posedge clk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    r_a     <= '0;
                    r_avail <= 1'b0;
                end else begin
                    r_avail <= bus.in_avail;
                    if (bus.in_avail)
                        r_a <= bus.a;
                end
            end

            assign w_s0_a     = r_a;
            assign w_s0_avail = r_avail;
        end else begin : g_in_direct
            assign w_s0_a     = bus.a;
            assign w_s0_avail = bus.in_avail;
        end
    endgenerate

    // ---------------- s1: accumulate ----------------
    assign w_last   = (r_cnt == CNT_LAST);
    // First element of a group starts from zero, so a stale acc never leaks across groups.
    assign w_acc_op = (r_cnt == '0) ? '0 : r_acc;

    mod_acc_add_core #(
        .MOD_W (MOD_W),
        .MOD_M (MOD_M)
    ) u_add_core (
        .i_x   (w_acc_op),
        .i_y   (w_s0_a),
        .o_sum (w_result)
    );

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_z         <= '0;
            r_out_avail <= 1'b0;
        end else begin
            r_out_avail <= 1'b0;
            if (w_s0_avail) begin
                if (w_last) begin
                    r_cnt       <= '0;
                    r_z         <= w_result;
                    r_out_avail <= 1'b1;
                end else begin
                    r_acc <= w_result;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.z         = r_z;
    assign bus.out_avail = r_out_avail;

    // ---------------- side data: stage 0 = input pipe, stage 1 = output ----------------
    genvar gi;
    generate
        if (SIDE_W > 0) begin : g_side
            logic [SIDE_WI-1:0] w_side_d  [2];
            logic [SIDE_WI-1:0] w_side_q  [2];
            logic               w_side_en [2];

            assign w_side_d[0]  = bus.in_side;
            assign w_side_en[0] = bus.in_avail;
            assign w_side_d[1]  = w_side_q[0];
            assign w_side_en[1] = w_s0_avail & w_last;

            for (gi = 0; gi < 2; gi++) begin : g_stage
                if (gi == 0 && IN_PIPE == 0) begin : g_bypass
                    assign w_side_q[gi] = w_side_d[gi];
                end else if (SIDE_RST_MODE == SIDE_RST_NONE) begin : g_noreset
                    logic [SIDE_WI-1:0] r_side;

                    always_ff @(posedge clk) begin
                        if (w_side_en[gi])
                            r_side <= w_side_d[gi];
                    end

                    assign w_side_q[gi] = r_side;
                end else begin : g_reset
                    logic [SIDE_WI-1:0] r_side;

                    always_ff @(posedge clk or negedge s_rst_n) begin
                        if (!s_rst_n)
                            r_side <= SIDE_RST_VAL;
                        else if (w_side_en[gi])
                            r_side <= w_side_d[gi];
                    end

                    assign w_side_q[gi] = r_side;
                end
            end

            assign bus.out_side = w_side_q[1];
        end else begin : g_no_side
            assign bus.out_side = '0;
        end
    endgenerate

`ifdef MOD_ACC_INPUT_CHECK_EN
    // Registered from the s0 element, so the flag rises in that element's s1 cycle.
    logic r_err;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n)
            r_err <= 1'b0;
        else if (w_s0_avail && (w_s0_a >= MOD_M))
            r_err <= 1'b1;
    end

    assign bus.out_err = r_err;
`endif

endmodule

// File: tb/tb_mod_acc.sv
// Directed table-driven bench for mod_acc: Goldilocks modulus, ACC_NB=4/IN_PIPE=1 and ACC_NB=1/IN_PIPE=0.
module tb_mod_acc;

    localparam logic [63:0] M  = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] M1 = M - 64'd1;

    typedef struct {
        logic        avail;
        logic [63:0] a;
        logic [7:0]  side;
        logic        exp_av;
        logic [63:0] exp_z;
        logic [7:0]  exp_side;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    mod_acc_if #(.MOD_W(64), .SIDE_W(8)) bus0 ();
    mod_acc_if #(.MOD_W(64), .SIDE_W(0)) bus1 ();

    mod_acc #(
        .MOD_W(64), .MOD_M(M), .ACC_NB(4), .IN_PIPE(1), .SIDE_W(8), .RST_SIDE(2'b01)
    ) u_dut0 (
        .clk     (clk),
        .s_rst_n (rst_n),
        .bus     (bus0)
    );

    mod_acc #(
        .MOD_W(64), .MOD_M(M), .ACC_NB(1), .IN_PIPE(0), .SIDE_W(0), .RST_SIDE(2'b00)
    ) u_dut1 (
        .clk     (clk),
        .s_rst_n (rst_n),
        .bus     (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic av, input logic [63:0] a, input logic [7:0] sd,
                                input logic eav, input logic [63:0] ez, input logic [7:0] es);
        vec_t v;
        v.avail = av; v.a = a; v.side = sd;
        v.exp_av = eav; v.exp_z = ez; v.exp_side = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic gav, input logic [63:0] gz, input logic [7:0] gs,
                       input logic eav, input logic [63:0] ez, input logic [7:0] es);
        n_vec++;
        if (gav !== eav || gz !== ez || gs !== es) begin
            n_err++;
            $display("FAIL %s: got av=%0b z=%h side=%h, want av=%0b z=%h side=%h",
                     nm, gav, gz, gs, eav, ez, es);
        end else begin
            $display("ok   %s: av=%0b z=%h side=%h", nm, gav, gz, gs);
        end
    endtask

    // Drive one cycle of dut0 stimulus, then sample 1 time unit after the capturing edge.
    task automatic apply0(input vec_t v, input string nm);
        bus0.in_avail = v.avail;
        bus0.a        = v.a;
        bus0.in_side  = v.side;
        @(posedge clk); #1;
        chk(nm, bus0.out_avail, bus0.z, bus0.out_side, v.exp_av, v.exp_z, v.exp_side);
    endtask

    task automatic apply1(input vec_t v, input string nm);
        bus1.in_avail = v.avail;
        bus1.a        = v.a;
        bus1.in_side  = 1'b0;
        @(posedge clk); #1;
        chk(nm, bus1.out_avail, bus1.z, {7'd0, bus1.out_side}, v.exp_av, v.exp_z, v.exp_side);
    endtask

`ifdef MOD_ACC_INPUT_CHECK_EN
    task automatic chk_err(input string nm, input logic exp_err);
        n_vec++;
        if (bus0.out_err !== exp_err) begin
            n_err++;
            $display("FAIL %s: got out_err=%0b, want %0b", nm, bus0.out_err, exp_err);
        end else begin
            $display("ok   %s: out_err=%0b", nm, bus0.out_err);
        end
    endtask
`endif

    vec_t tbl0 [24];
    vec_t tbl1 [5];

    initial begin
        n_vec = 0;
        n_err = 0;

        // group sum 1+2+3+4, then wrap M-1,M-1,1,1, then two groups of 5 with a 3-cycle bubble
        tbl0[0]  = mk(1, 64'd1, 8'h11, 0, 64'd0,  8'h00);
        tbl0[1]  = mk(1, 64'd2, 8'h12, 0, 64'd0,  8'h00);
        tbl0[2]  = mk(1, 64'd3, 8'h13, 0, 64'd0,  8'h00);
        tbl0[3]  = mk(1, 64'd4, 8'h14, 0, 64'd0,  8'h00);
        tbl0[4]  = mk(0, 64'd0, 8'h00, 1, 64'd10, 8'h14);
        tbl0[5]  = mk(0, 64'd0, 8'h00, 0, 64'd10, 8'h14);
        tbl0[6]  = mk(1, M1,    8'h21, 0, 64'd10, 8'h14);
        tbl0[7]  = mk(1, M1,    8'h22, 0, 64'd10, 8'h14);
        tbl0[8]  = mk(1, 64'd1, 8'h23, 0, 64'd10, 8'h14);
        tbl0[9]  = mk(1, 64'd1, 8'h24, 0, 64'd10, 8'h14);
        tbl0[10] = mk(0, 64'd0, 8'h00, 1, 64'd0,  8'h24);
        tbl0[11] = mk(1, 64'd5, 8'h31, 0, 64'd0,  8'h24);
        tbl0[12] = mk(1, 64'd5, 8'h32, 0, 64'd0,  8'h24);
        tbl0[13] = mk(0, 64'd0, 8'h00, 0, 64'd0,  8'h24);
        tbl0[14] = mk(0, 64'd0, 8'h00, 0, 64'd0,  8'h24);
        tbl0[15] = mk(0, 64'd0, 8'h00, 0, 64'd0,  8'h24);
        tbl0[16] = mk(1, 64'd5, 8'h33, 0, 64'd0,  8'h24);
        tbl0[17] = mk(1, 64'd5, 8'h34, 0, 64'd0,  8'h24);
        tbl0[18] = mk(1, 64'd5, 8'h35, 1, 64'd20, 8'h34);
        tbl0[19] = mk(1, 64'd5, 8'h36, 0, 64'd20, 8'h34);
        tbl0[20] = mk(1, 64'd5, 8'h37, 0, 64'd20, 8'h34);
        tbl0[21] = mk(1, 64'd5, 8'h38, 0, 64'd20, 8'h34);
        tbl0[22] = mk(0, 64'd0, 8'h00, 1, 64'd20, 8'h38);
        tbl0[23] = mk(0, 64'd0, 8'h00, 0, 64'd20, 8'h38);

        // ACC_NB=1, IN_PIPE=0: each input appears one edge later, full throughput
        tbl1[0] = mk(1, 64'hABC, 8'h00, 1, 64'hABC, 8'h00);
        tbl1[1] = mk(1, 64'hABC, 8'h00, 1, 64'hABC, 8'h00);
        tbl1[2] = mk(1, 64'h123, 8'h00, 1, 64'h123, 8'h00);
        tbl1[3] = mk(1, M1,      8'h00, 1, M1,      8'h00);
        tbl1[4] = mk(0, 64'd0,   8'h00, 0, M1,      8'h00);

        rst_n = 1'b0;
        bus0.in_avail = 1'b0; bus0.a = '0; bus0.in_side = '0;
        bus1.in_avail = 1'b0; bus1.a = '0; bus1.in_side = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dut0", bus0.out_avail, bus0.z, bus0.out_side, 1'b0, 64'd0, 8'h00);
        chk("reset_dut1", bus1.out_avail, bus1.z, {7'd0, bus1.out_side}, 1'b0, 64'd0, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++)
            apply0(tbl0[i], $sformatf("dut0_vec%0d", i));

        // reset mid-group: the two partial 7s must be discarded
        apply0(mk(1, 64'd7, 8'h51, 0, 64'd20, 8'h38), "rstmid_in7a");
        apply0(mk(1, 64'd7, 8'h52, 0, 64'd20, 8'h38), "rstmid_in7b");
        bus0.in_avail = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_async", bus0.out_avail, bus0.z, bus0.out_side, 1'b0, 64'd0, 8'h00);
        @(posedge clk); #1;
        chk("rstmid_held", bus0.out_avail, bus0.z, bus0.out_side, 1'b0, 64'd0, 8'h00);
        rst_n = 1'b1;
        apply0(mk(1, 64'd1, 8'h61, 0, 64'd0, 8'h00), "rstmid_in1a");
        apply0(mk(1, 64'd1, 8'h62, 0, 64'd0, 8'h00), "rstmid_in1b");
        apply0(mk(1, 64'd1, 8'h63, 0, 64'd0, 8'h00), "rstmid_in1c");
        apply0(mk(1, 64'd1, 8'h64, 0, 64'd0, 8'h00), "rstmid_in1d");
        apply0(mk(0, 64'd0, 8'h00, 1, 64'd4, 8'h64), "rstmid_out");
        apply0(mk(0, 64'd0, 8'h00, 0, 64'd4, 8'h64), "rstmid_idle");

        for (int i = 0; i < 5; i++)
            apply1(tbl1[i], $sformatf("dut1_vec%0d", i));

`ifdef MOD_ACC_INPUT_CHECK_EN
        bus0.in_avail = 1'b1; bus0.a = M1; bus0.in_side = 8'h00;
        @(posedge clk); #1; chk_err("err_m1_s0", 1'b0);
        bus0.in_avail = 1'b0;
        @(posedge clk); #1; chk_err("err_m1_s1", 1'b0);
        @(posedge clk); #1; chk_err("err_m1_idle", 1'b0);
        bus0.in_avail = 1'b1; bus0.a = M;
        @(posedge clk); #1; chk_err("err_m_s0", 1'b0);
        bus0.in_avail = 1'b0;
        @(posedge clk); #1; chk_err("err_m_s1", 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; chk_err($sformatf("err_sticky%0d", i), 1'b1);
        end
        rst_n = 1'b0;
        #1; chk_err("err_reset", 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1; chk_err("err_after_reset", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
